// File: rtl/instr_fetch.sv
// Instruction fetch stage: loads a program image into instr_mem, then fetches
// opcodes into a one-entry valid/ready register with branch redirect and halt.
module instr_fetch #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 26,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              start_run,
  input  logic [DATA_W-1:0] opcode,
  output logic [ADDR_W-1:0] prog_pointer,
  output logic              write_data,
  output logic [DATA_W-1:0] data_to_write,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              halted_q;

  logic in_load_s;
  logic load_xfer_s;
  logic fire_s;
  logic is_halt_s;

  assign in_load_s   = (state_q == S_LOAD);
  assign load_xfer_s = in_load_s & load_valid;
  // Branch pre-empts the fetch so the redirect target is read on the next cycle.
  assign fire_s      = (state_q == S_RUN) & ~branch_en & (~valid_q | instr_ready);
  assign is_halt_s   = (opcode[DATA_W-1 -: 4] == HALT_OP);

  // Next-state logic for mode, program pointer and instruction register.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d = S_LOAD;
          ptr_d   = PTR_ZERO;
        end else if (start_run) begin
          state_d = S_RUN;
          ptr_d   = PTR_ZERO;
          valid_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (load_xfer_s) begin
          if (ptr_q == PTR_LAST) begin
            state_d = S_IDLE;
            ptr_d   = PTR_ZERO;
          end else begin
            ptr_d   = ptr_q + PTR_ONE;
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      S_RUN, S_HALT: begin
        if (branch_en) begin
          state_d = S_RUN;
          valid_d = 1'b0;
          ptr_d   = branch_target;
        end else if (fire_s) begin
          valid_d = 1'b1;
          instr_d = opcode;
          pc_d    = ptr_q;
          // A halt instruction is still delivered; the pointer stays on it.
          if (is_halt_s) begin
            state_d = S_HALT;
          end else begin
            ptr_d   = ptr_q + PTR_ONE;
          end
        end else if ((state_q == S_HALT) && start_run) begin
          state_d = S_RUN;
          ptr_d   = PTR_ZERO;
          valid_d = 1'b0;
        end else if (valid_q && instr_ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = PTR_ZERO;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= PTR_ZERO;
      pc_q     <= PTR_ZERO;
      instr_q  <= {DATA_W{1'b0}};
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= (state_d == S_HALT);
    end
  end

  assign load_ready    = in_load_s;
  assign write_data    = load_xfer_s;
  assign data_to_write = in_load_s ? load_data : {DATA_W{1'b0}};
  assign prog_pointer  = ptr_q;
  assign instr_valid   = valid_q;
  assign instr_out     = instr_q;
  assign instr_pc      = pc_q;
  assign halted        = halted_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits between the program loader and decode, directly upstream of `instr_mem`. It owns the program pointer and drives `instr_mem`'s address, write strobe and write data. In LOAD mode it streams a program image into memory; in RUN mode it reads opcodes and hands them to decode through a one-entry valid/ready instruction register, with branch redirect and halt detection.

## Interface
- `ADDR_W`, 4, program pointer width; memory depth is 2^ADDR_W (16).
- `DATA_W`, 26, opcode width.
- `HALT_OP`, 4'hF, value of `opcode[DATA_W-1:DATA_W-4]` that marks a halt instruction.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start_load`  in  1  pulse in IDLE to begin loading a program image.
- `load_valid`  in  1  `load_data` holds a valid word.
- `load_data`  in  DATA_W  program word to store.
- `load_ready`  out  1  high in LOAD; a word transfers when `load_valid & load_ready`.
- `start_run`  in  1  pulse in IDLE or HALT to begin execution at address 0.
- `opcode`  in  DATA_W  combinational read data from `instr_mem` at `prog_pointer`.
- `prog_pointer`  out  ADDR_W  address to `instr_mem`.
- `write_data`  out  1  write strobe to `instr_mem`.
- `data_to_write`  out  DATA_W  write data to `instr_mem`.
- `instr_valid`  out  1  `instr_out`/`instr_pc` hold an instruction.
- `instr_ready`  in  1  decode accepts the instruction this cycle.
- `instr_out`  out  DATA_W  fetched opcode.
- `instr_pc`  out  ADDR_W  address the instruction came from.
- `branch_en`  in  1  redirect fetch (from execute).
- `branch_target`  in  ADDR_W  redirect address.
- `halted`  out  1  high in HALT.

## Operation
- States: IDLE, LOAD, RUN, HALT. Reset enters IDLE.
- IDLE: `start_load` -> LOAD, pointer := 0. `start_run` -> RUN, pointer := 0. Both asserted: LOAD wins.
- LOAD: `load_ready`=1. `write_data` = `load_valid` (combinational); `data_to_write` = `load_data` (combinational). Each transfer increments the pointer. A transfer at pointer 2^ADDR_W-1 returns to IDLE with pointer := 0. No transfer means the pointer holds. `start_run` and `branch_en` are ignored.
- RUN: fetch fires when `!instr_valid | instr_ready`. Fire: `instr_out` := `opcode`, `instr_pc` := pointer, `instr_valid` := 1, pointer := pointer+1 (wraps 15->0). When `instr_valid & instr_ready` and no fire is possible, `instr_valid` := 0. Otherwise the register holds and is stable while `!instr_ready`.
- Halt: a fire whose `opcode[25:22]==HALT_OP` still delivers that instruction. The state then goes to HALT and the pointer does not advance.
- HALT: no fetches. The pending instruction drains normally via `instr_ready`. `start_run` -> RUN, pointer := 0, `instr_valid` := 0.
- Branch (RUN or HALT): `branch_en` has priority over fetch and over the halt transition. It sets `instr_valid` := 0 (flushing any unaccepted instruction), pointer := `branch_target`, state := RUN. The next fetch happens the following cycle.
- `write_data` is 0 in every state except LOAD.

## Timing
- Reset values: `prog_pointer`=0, `write_data`=0, `data_to_write`=0, `load_ready`=0, `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `halted`=0.
- Reset asserted mid-LOAD or mid-RUN returns to IDLE immediately. Memory contents are not the block's concern.
- Fetch latency is 1 cycle: pointer presented in cycle N gives `instr_valid` at N+1.
- Sustained throughput is 1 instruction/cycle with `instr_ready` held high.
- Branch asserted at edge N gives target data at edge N+1, so 1 bubble cycle.
- Load throughput is 1 word/cycle. A full image takes 16 transfers; `load_ready` drops the cycle after the 16th.
- `halted` is registered and rises the cycle after the halt instruction is fired.

## Test plan
- Load 16 words 26'h0000000+i with `load_valid` held high. Expect `write_data`=1 for 16 consecutive cycles, `prog_pointer` 0..15, then IDLE with pointer 0. Read back all 16 addresses in RUN.
- Run with `instr_ready`=1. Expect `instr_pc` 0,1,2,...,15,0 on consecutive cycles with matching `instr_out`, one per cycle after 1-cycle latency.
- Hold `instr_ready`=0 for 3 cycles at pc 5. Expect `instr_out`/`instr_pc`=5 held stable, no pointer advance, then resume at 6.
- At pc 3, pulse `branch_en` with target 12. Expect the pending instruction flushed (`instr_valid`=0 for one cycle), then `instr_pc`=12, 13.
- Place 26'h3C00000 (top nibble F) at address 7. Expect instruction 7 delivered, `halted`=1 next cycle, no further fetches. `start_run` restarts at pc 0.
- Assert reset mid-LOAD at pointer 9 with `load_valid` gaps. Expect all outputs at reset values immediately; a subsequent `start_load` restarts at address 0.
